// File: rtl/sdram_arb2.sv
// Two-port valid/ready arbiter in front of a single SDRAM controller request port.
// Optional round-robin tie-break enabled by defining SDRAM_ARB_RR_EN (default: fixed priority, port 0 wins).
module sdram_arb2 #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p0_valid,
    input  logic [ADDR_W-1:0]     p0_addr,
    input  logic [DATA_W-1:0]     p0_din,
    input  logic [DATA_W/8-1:0]   p0_wmask,
    output logic [DATA_W-1:0]     p0_dout,
    output logic                  p0_ready,
    input  logic                  p1_valid,
    input  logic [ADDR_W-1:0]     p1_addr,
    input  logic [DATA_W-1:0]     p1_din,
    input  logic [DATA_W/8-1:0]   p1_wmask,
    output logic [DATA_W-1:0]     p1_dout,
    output logic                  p1_ready,
    output logic                  m_valid,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_din,
    output logic [DATA_W/8-1:0]   m_wmask,
    input  logic [DATA_W-1:0]     m_dout,
    input  logic                  m_ready,
    output logic [1:0]            grant,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  m_valid_q, m_valid_d;
    logic [ADDR_W-1:0]     m_addr_q, m_addr_d;
    logic [DATA_W-1:0]     m_din_q, m_din_d;
    logic [DATA_W/8-1:0]   m_wmask_q, m_wmask_d;
    logic [1:0]            grant_q, grant_d;
    logic                  busy_q, busy_d;
    logic [DATA_W-1:0]     p0_dout_q, p0_dout_d;
    logic [DATA_W-1:0]     p1_dout_q, p1_dout_d;
    logic                  p0_ready_q, p0_ready_d;
    logic                  p1_ready_q, p1_ready_d;
    logic                  pick_p1;
`ifdef SDRAM_ARB_RR_EN
    // 1 = port 1 was served last, so port 0 wins the next tie
    logic                  last_q, last_d;
`endif

    always_comb begin
        state_d    = state_q;
        m_valid_d  = m_valid_q;
        m_addr_d   = m_addr_q;
        m_din_d    = m_din_q;
        m_wmask_d  = m_wmask_q;
        grant_d    = grant_q;
        busy_d     = busy_q;
        p0_dout_d  = p0_dout_q;
        p1_dout_d  = p1_dout_q;
        p0_ready_d = p0_ready_q;
        p1_ready_d = p1_ready_q;
`ifdef SDRAM_ARB_RR_EN
        last_d     = last_q;
        pick_p1    = p1_valid && (!p0_valid || !last_q);
`else
        pick_p1    = p1_valid && !p0_valid;
`endif

        case (state_q)
            IDLE: begin
                if (p0_valid || p1_valid) begin
                    m_valid_d = 1'b1;
                    busy_d    = 1'b1;
                    grant_d   = pick_p1 ? 2'b10 : 2'b01;
                    m_addr_d  = pick_p1 ? p1_addr  : p0_addr;
                    m_din_d   = pick_p1 ? p1_din   : p0_din;
                    m_wmask_d = pick_p1 ? p1_wmask : p0_wmask;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = RESP;
                    if (grant_q[1]) begin
                        p1_dout_d  = m_dout;
                        p1_ready_d = 1'b1;
                    end else begin
                        p0_dout_d  = m_dout;
                        p0_ready_d = 1'b1;
                    end
                end
            end
            RESP: begin
                p0_ready_d = 1'b0;
                p1_ready_d = 1'b0;
                grant_d    = 2'b00;
                busy_d     = 1'b0;
                m_addr_d   = '0;
                m_din_d    = '0;
                m_wmask_d  = '0;
`ifdef SDRAM_ARB_RR_EN
                last_d     = grant_q[1];
`endif
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            m_valid_q  <= 1'b0;
            m_addr_q   <= '0;
            m_din_q    <= '0;
            m_wmask_q  <= '0;
            grant_q    <= 2'b00;
            busy_q     <= 1'b0;
            p0_dout_q  <= '0;
            p1_dout_q  <= '0;
            p0_ready_q <= 1'b0;
            p1_ready_q <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
            last_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            m_valid_q  <= m_valid_d;
            m_addr_q   <= m_addr_d;
            m_din_q    <= m_din_d;
            m_wmask_q  <= m_wmask_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            p0_dout_q  <= p0_dout_d;
            p1_dout_q  <= p1_dout_d;
            p0_ready_q <= p0_ready_d;
            p1_ready_q <= p1_ready_d;
`ifdef SDRAM_ARB_RR_EN
            last_q     <= last_d;
`endif
        end
    end

    assign m_valid  = m_valid_q;
    assign m_addr   = m_addr_q;
    assign m_din    = m_din_q;
    assign m_wmask  = m_wmask_q;
    assign grant    = grant_q;
    assign busy     = busy_q;
    assign p0_dout  = p0_dout_q;
    assign p1_dout  = p1_dout_q;
    assign p0_ready = p0_ready_q;
    assign p1_ready = p1_ready_q;

endmodule
